// File: rtl/tdm_demux_if.sv
// Bus bundle for the 1-to-4 TDM demultiplexer: slot stream in, frame outputs out.
interface tdm_demux_if #(
    parameter int W = 1
);
    logic         en;
    logic [W-1:0] din;
    logic         frame_sync;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [1:0]   sel;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;

    modport master (
        output en, din, frame_sync,
        input  a, b, c, d, sel, frame_valid, sync_err, locked
    );

    modport slave (
        input  en, din, frame_sync,
        output a, b, c, d, sel, frame_valid, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux_1x4.sv
// 1-to-4 TDM demultiplexer. Slots a,b,c,d arrive on din, one per enabled edge.
// frame_sync marks slot a. A complete frame is published to a..d in one step.
//
// state | meaning
// HUNT  | waiting for frame_sync to find slot a
// RUN   | locked, collecting slots in order a,b,c,d
module tdm_demux_1x4 #(
    parameter int W = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    tdm_demux_if.slave    bus
);
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   r_state;
    logic [1:0]   r_sel;
    logic [W-1:0] r_sh_a;
    logic [W-1:0] r_sh_b;
    logic [W-1:0] r_sh_c;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_c;
    logic [W-1:0] r_d;
    logic         r_frame_valid;
    logic         r_sync_err;

    // Slot tracking, shadow capture and frame publication; pulses self-clear every cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_HUNT;
            r_sel         <= 2'b00;
            r_sh_a        <= '0;
            r_sh_b        <= '0;
            r_sh_c        <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    ST_HUNT: begin
                        if (bus.frame_sync) begin
                            r_sh_a  <= bus.din;
                            r_sel   <= 2'b01;
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        if (r_sel == 2'b00) begin
                            if (bus.frame_sync) begin
                                r_sh_a <= bus.din;
                                r_sel  <= 2'b01;
                            end else begin
                                // Missing sync where slot a was due: lose lock.
                                r_sync_err <= 1'b1;
                                r_state    <= ST_HUNT;
                                r_sel      <= 2'b00;
                            end
                        end else if (bus.frame_sync) begin
                            // Early sync: drop the partial frame and restart on this sample.
                            r_sync_err <= 1'b1;
                            r_sh_a     <= bus.din;
                            r_sel      <= 2'b01;
                        end else begin
                            case (r_sel)
                                2'b01: begin
                                    r_sh_b <= bus.din;
                                    r_sel  <= 2'b10;
                                end
                                2'b10: begin
                                    r_sh_c <= bus.din;
                                    r_sel  <= 2'b11;
                                end
                                default: begin
                                    r_a           <= r_sh_a;
                                    r_b           <= r_sh_b;
                                    r_c           <= r_sh_c;
                                    r_d           <= bus.din;
                                    r_frame_valid <= 1'b1;
                                    r_sel         <= 2'b00;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign bus.a           = r_a;
    assign bus.b           = r_b;
    assign bus.c           = r_c;
    assign bus.d           = r_d;
    assign bus.sel         = r_sel;
    assign bus.frame_valid = r_frame_valid;
    assign bus.sync_err    = r_sync_err;
    assign bus.locked      = (r_state == ST_RUN);
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed bench for tdm_demux_1x4 at W=4.
module tb_tdm_demux_1x4;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    tdm_demux_if #(.W(4)) bus ();

    tdm_demux_1x4 #(.W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs at negedge, then settle just after the rising edge.
    task automatic step(input logic e, input logic fs, input logic [3:0] d);
        @(negedge clk);
        bus.en         = e;
        bus.frame_sync = fs;
        bus.din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'hF);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abcd: got %h want 0000", {bus.a, bus.b, bus.c, bus.d});
        end
        checks++;
        if ({bus.sel, bus.locked, bus.frame_valid, bus.sync_err} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got sel/lock/fv/se=%b want 00000",
                     {bus.sel, bus.locked, bus.frame_valid, bus.sync_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if ({bus.sel, bus.locked} !== 3'b011) begin
            errors++;
            $display("FAIL basic_slot0: got sel/lock=%b want 011", {bus.sel, bus.locked});
        end
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h0);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL basic_partial_hidden: got %h fv=%b want 0000 fv=0",
                     {bus.a, bus.b, bus.c, bus.d}, bus.frame_valid);
        end
        step(1'b1, 1'b0, 4'h1);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 16'h0101) begin
            errors++;
            $display("FAIL basic_abcd: got %h want 0101", {bus.a, bus.b, bus.c, bus.d});
        end
        checks++;
        if ({bus.frame_valid, bus.sync_err, bus.locked, bus.sel} !== 5'b10100) begin
            errors++;
            $display("FAIL basic_ctrl: got fv/se/lock/sel=%b want 10100",
                     {bus.frame_valid, bus.sync_err, bus.locked, bus.sel});
        end
        step(1'b0, 1'b0, 4'hE);
        checks++;
        if ({bus.frame_valid, bus.a, bus.b, bus.c, bus.d} !== {1'b0, 16'h0101}) begin
            errors++;
            $display("FAIL basic_fv_drop: got fv=%b %h want fv=0 0101",
                     bus.frame_valid, {bus.a, bus.b, bus.c, bus.d});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [8];
        int         fv_at [$];
        int         se_cnt;
        vals = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
        se_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 4) == 0, vals[i]);
            if (bus.frame_valid) fv_at.push_back(i);
            if (bus.sync_err) se_cnt++;
            if (i == 3) begin
                checks++;
                if ({bus.a, bus.b, bus.c, bus.d} !== 16'h0101) begin
                    errors++;
                    $display("FAIL b2b_first: got %h want 0101", {bus.a, bus.b, bus.c, bus.d});
                end
            end
        end
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 16'h1010) begin
            errors++;
            $display("FAIL b2b_second: got %h want 1010", {bus.a, bus.b, bus.c, bus.d});
        end
        checks++;
        if (fv_at.size() != 2 || fv_at[0] != 3 || fv_at[1] != 7) begin
            errors++;
            $display("FAIL b2b_fv_spacing: got %0d pulses want 2 at steps 3,7", fv_at.size());
        end
        checks++;
        if (se_cnt != 0) begin
            errors++;
            $display("FAIL b2b_no_sync_err: got %0d want 0", se_cnt);
        end
    endtask

    task automatic test_en_stall();
        logic [3:0] vals [4];
        vals = '{4'h0, 4'h1, 4'h0, 4'h1};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, vals[i]);
            if (i < 3) begin
                step(1'b0, 1'b1, 4'hF);
                checks++;
                if ({bus.sel, bus.sync_err, bus.a, bus.b, bus.c, bus.d} !==
                    {2'(i + 1), 1'b0, 16'h1010}) begin
                    errors++;
                    $display("FAIL stall_%0d: got sel=%0d se=%b %h want sel=%0d se=0 1010",
                             i, bus.sel, bus.sync_err, {bus.a, bus.b, bus.c, bus.d}, i + 1);
                end
            end
        end
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {16'h0101, 1'b1}) begin
            errors++;
            $display("FAIL stall_done: got %h fv=%b want 0101 fv=1",
                     {bus.a, bus.b, bus.c, bus.d}, bus.frame_valid);
        end
    endtask

    task automatic test_early_sync();
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b1, 4'h7);
        checks++;
        if ({bus.sync_err, bus.frame_valid, bus.locked, bus.sel} !== 5'b10101) begin
            errors++;
            $display("FAIL early_ctrl: got se/fv/lock/sel=%b want 10101",
                     {bus.sync_err, bus.frame_valid, bus.locked, bus.sel});
        end
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 16'h0101) begin
            errors++;
            $display("FAIL early_hold: got %h want 0101", {bus.a, bus.b, bus.c, bus.d});
        end
        step(1'b1, 1'b0, 4'h0);
        checks++;
        if (bus.sync_err !== 1'b0) begin
            errors++;
            $display("FAIL early_se_drop: got %b want 0", bus.sync_err);
        end
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h1);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {16'h7001, 1'b1}) begin
            errors++;
            $display("FAIL early_frame: got %h fv=%b want 7001 fv=1",
                     {bus.a, bus.b, bus.c, bus.d}, bus.frame_valid);
        end
    endtask

    task automatic test_missing_sync();
        step(1'b1, 1'b0, 4'h9);
        checks++;
        if ({bus.sync_err, bus.locked, bus.sel, bus.a, bus.b, bus.c, bus.d} !==
            {1'b1, 1'b0, 2'b00, 16'h7001}) begin
            errors++;
            $display("FAIL miss_unlock: got se=%b lock=%b sel=%0d %h want se=1 lock=0 sel=0 7001",
                     bus.sync_err, bus.locked, bus.sel, {bus.a, bus.b, bus.c, bus.d});
        end
        step(1'b1, 1'b0, 4'h2);
        checks++;
        if ({bus.sync_err, bus.locked, bus.sel} !== 4'b0000) begin
            errors++;
            $display("FAIL miss_hunt: got se/lock/sel=%b want 0000",
                     {bus.sync_err, bus.locked, bus.sel});
        end
        step(1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b0, 4'h4);
        step(1'b1, 1'b0, 4'h5);
        step(1'b1, 1'b0, 4'h6);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid, bus.locked} !== {16'h3456, 2'b11}) begin
            errors++;
            $display("FAIL miss_relock: got %h fv=%b lock=%b want 3456 fv=1 lock=1",
                     {bus.a, bus.b, bus.c, bus.d}, bus.frame_valid, bus.locked);
        end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 4'h4);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.sel, bus.locked, bus.frame_valid, bus.sync_err} !==
            21'h0) begin
            errors++;
            $display("FAIL midreset: got %h sel=%0d lock=%b fv=%b se=%b want all 0",
                     {bus.a, bus.b, bus.c, bus.d}, bus.sel, bus.locked, bus.frame_valid,
                     bus.sync_err);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b0, 4'h5);
        checks++;
        if ({bus.locked, bus.sel, bus.sync_err} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_hunt: got lock/sel/se=%b want 0000",
                     {bus.locked, bus.sel, bus.sync_err});
        end
        step(1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b0, 4'hA);
        step(1'b1, 1'b0, 4'h5);
        step(1'b1, 1'b0, 4'hF);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {16'h3A5F, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_frame: got %h fv=%b want 3a5f fv=1",
                     {bus.a, bus.b, bus.c, bus.d}, bus.frame_valid);
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.frame_sync = 1'b0;
        bus.din        = 4'h0;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_en_stall();
        test_early_sync();
        test_missing_sync();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
